serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that drives a single 1-bit full-adder slice, built from two half adders, across WIDTH cycles.
- Adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a start/done handshake so upstream logic can share one small adder datapath instead of a WIDTH-bit ripple adder.
- Contains the operand shift registers, carry flip-flop, bit counter and sequencing FSM.

Parameters:
- WIDTH, 4: operand and result width in bits. Legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the edge where start is accepted
- b  input  WIDTH  operand B; captured on the edge where start is accepted
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  single-cycle pulse: sum and carry_out are valid
- sum  output  WIDTH  result bits, registered
- carry_out  output  1  final carry out of the MSB, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1 at a clock edge:
  - state <= IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - Internal shift registers, carry flip-flop and counter all clear to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, capture a into a_sr and b into b_sr, clear the carry flip-flop c and counter cnt, and go to RUN.
  - If start=0, stay in IDLE.
  - sum and carry_out keep their previous values.
- RUN (busy=1), on each edge:
  - s = a_sr[0] ^ b_sr[0] ^ c.
  - c <= (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])).
  - a_sr and b_sr shift right by 1.
  - s shifts into the MSB of the result shift register.
  - cnt increments.
  - On the edge where cnt==WIDTH-1, transfer the result register to sum and the new carry to carry_out, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state is IDLE unconditionally.
  - A start asserted during DONE is ignored; the requester must hold or re-assert it.
- Latency:
  - start is accepted at edge E0.
  - RUN occupies edges E1..EW.
  - done is high in the cycle after EW.
  - Total: start accepted, then done, WIDTH+1 cycles later.
  - Throughput: one addition per WIDTH+2 cycles when start is held high continuously.
- Output stability: sum and carry_out change only at the RUN-to-DONE edge (or on reset). They hold their value across IDLE and the next RUN until the following DONE.
- start while busy=1: ignored. Operands are not re-sampled and the sequence is unaffected.
- Changes on a/b after acceptance: no effect on the result.
- Arithmetic: unsigned, modulo 2^WIDTH. carry_out is bit WIDTH of a+b.
- WIDTH=1: a single RUN cycle, so done follows 2 cycles after start is accepted.
- Reset mid-RUN: the operation is abandoned, state returns to IDLE, no done pulse is issued, and sum and carry_out read 0.
- Reset asserted together with start: reset wins.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1, b is captured inverted (~b) and c is initialised to 1, so the result is a-b modulo 2^WIDTH.
  - carry_out=1 means no borrow (a>=b).
  - When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; addition only; c is always initialised to 0.

Test Plan:
- Basic add, no carry: WIDTH=4, rst high 2 cycles then low; a=3, b=5, start pulse for 1 cycle.
  - Expect busy high exactly 4 cycles.
  - Expect done pulse 1 cycle in the 5th cycle after acceptance, with sum=8, carry_out=0.
  - Expect busy=0 while done=1.
- Carry out and wrap: a=15, b=1 -> sum=0, carry_out=1.
  - Follow with a=0, b=0 -> sum=0, carry_out=0.
  - Follow with a=15, b=15 -> sum=14, carry_out=1.
- Start ignored while busy and during DONE: a=2, b=2 accepted.
  - Pulse start with a=7, b=7 during RUN and again during DONE.
  - Expect a single done with sum=4, carry_out=0, and no second operation started.
- Back-to-back operation: start held high continuously with a=1, b=2.
  - Expect done pulses spaced every WIDTH+2=6 cycles, each with sum=3.
  - Expect sum stable between pulses.
- Reset mid-operation: accept a=9, b=9, then assert rst in the 2nd RUN cycle.
  - Expect state IDLE, busy=0, sum=0, carry_out=0, and no done pulse.
  - A subsequent a=9, b=9 gives sum=2, carry_out=1.
- Optional feature, with SERIAL_ADD_SUB_EN defined:
  - sub=1, a=5, b=3 -> sum=2, carry_out=1.
  - sub=1, a=3, b=5 -> sum=14, carry_out=0.
  - sub=0, a=3, b=5 -> sum=8, carry_out=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for a-b via inverted b and carry-in 1.
//
// state | meaning
// IDLE  | waiting for start; sum/carry_out hold last result
// RUN   | one operand bit per clock through the adder slice
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_q, c_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sub_bit;
    logic               ha1_s, ha1_c, ha2_s, ha2_c;
    logic               c_nxt;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_bit = sub;
`else
    assign sub_bit = 1'b0;
`endif

    // Full-adder slice built from two half adders.
    assign ha1_s = a_sr_q[0] ^ b_sr_q[0];
    assign ha1_c = a_sr_q[0] & b_sr_q[0];
    assign ha2_s = ha1_s ^ c_q;
    assign ha2_c = ha1_s & c_q;
    assign c_nxt = ha1_c | ha2_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = sub_bit ? ~b : b;
                    c_d     = sub_bit;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = (res_q >> 1) | (WIDTH'(ha2_s) << (WIDTH - 1));
                c_d    = c_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_d;
                    carry_d = c_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule
